// File: rtl/fpaccum.sv
// rtl/fpaccum.sv - saturating fixed-point dot-product accumulator behind the multiplier
//
// Purpose: sums a programmable number of n-bit product terms from a val/rdy
// stream. It then presents one saturated n-bit result with an overflow flag.
// The result uses the multiplier's Q format, so terms are added with no
// realignment.
//
// Ports:
//   clk       in   1         rising-edge clock
//   reset     in   1         asynchronous active-high reset, clears all state
//   recv_val  in   1         product term valid
//   recv_rdy  out  1         accumulator can take a term (low only while a result is pending)
//   recv_msg  in   n         product term
//   count     in   len_bits  terms in this sum (0 acts as 1), sampled on the first beat only
//   send_val  out  1         result valid
//   send_rdy  in   1         downstream accepts the result
//   send_msg  out  n         saturated sum
//   overflow  out  1         sum was clamped (qualified by send_val)

module fpaccum #(
    parameter int n        = 32,
    parameter int sign     = 1,
    parameter int len_bits = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                recv_val,
    output logic                recv_rdy,
    input  logic [n-1:0]        recv_msg,
    input  logic [len_bits-1:0] count,
    output logic                send_val,
    input  logic                send_rdy,
    output logic [n-1:0]        send_msg,
    output logic                overflow
);

    // len_bits guard bits hold up to 2^len_bits-1 full-scale terms without wrapping.
    localparam int acc_w = n + len_bits;
    localparam logic [len_bits-1:0] len_one = len_bits'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [acc_w-1:0]    acc_q;
    logic [len_bits-1:0] remaining_q;
    logic [n-1:0]        send_msg_q;
    logic                overflow_q;

    logic [acc_w-1:0]    term_ext;
    logic [acc_w-1:0]    acc_d;
    logic [len_bits-1:0] remaining_d;
    logic [n-1:0]        sat_msg_d;
    logic                sat_ovf_d;

    always_comb begin
        term_ext = (sign != 0) ? {{len_bits{recv_msg[n-1]}}, recv_msg}
                               : {{len_bits{1'b0}}, recv_msg};

        // The first beat of a sum restarts the accumulator instead of adding to it.
        // That is how stale partial sums are prevented.
        if (state_q == IDLE) begin
            acc_d       = term_ext;
            remaining_d = (count == '0) ? '0 : count - len_one;
        end else begin
            acc_d       = acc_q + term_ext;
            remaining_d = remaining_q - len_one;
        end

        // Clamp on the final sum only. The result fits in n bits when the top
        // len_bits+1 bits (signed) or the top len_bits bits (unsigned) carry no information.
        sat_msg_d = acc_d[n-1:0];
        sat_ovf_d = 1'b0;
        if (sign != 0) begin
            if (acc_d[acc_w-1:n-1] != {(len_bits+1){acc_d[acc_w-1]}}) begin
                sat_ovf_d = 1'b1;
                sat_msg_d = acc_d[acc_w-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
            end
        end else begin
            if (acc_d[acc_w-1:n] != '0) begin
                sat_ovf_d = 1'b1;
                sat_msg_d = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            send_msg_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (recv_val) begin
                        acc_q       <= acc_d;
                        remaining_q <= remaining_d;
                        if (remaining_d == '0) begin
                            state_q    <= DONE;
                            send_msg_q <= sat_msg_d;
                            overflow_q <= sat_ovf_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // No term is taken while the result is offered. The next sum starts from IDLE.
                    if (send_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign recv_rdy = (state_q != DONE);
    assign send_val = (state_q == DONE);
    assign send_msg = send_msg_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fpaccum.sv
// tb/tb_fpaccum.sv - scoreboard testbench for fpaccum with a sum-and-clamp reference model

module tb_fpaccum;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] recv_msg;
    logic [7:0]  count;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] send_msg;
    logic        overflow;

    fpaccum #(.n(32), .sign(1), .len_bits(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .count    (count),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] msg;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rdy_random = 1'b0;
    bit   rdy_forced = 1'b1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer sum of all terms, then clamp to the 32-bit signed range.
    function automatic exp_t model(logic [31:0] terms[$]);
        longint s = 0;
        exp_t   e;
        foreach (terms[i]) s += longint'($signed(terms[i]));
        if (s > 64'sd2147483647) begin
            e.msg = 32'h7FFF_FFFF; e.ovf = 1'b1;
        end else if (s < -64'sd2147483648) begin
            e.msg = 32'h8000_0000; e.ovf = 1'b1;
        end else begin
            e.msg = s[31:0];       e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Downstream ready: random, or forced by the test sequence.
    always @(posedge clk) begin
        #2;
        send_rdy = rdy_random ? 1'($urandom_range(0, 1)) : rdy_forced;
    end

    // Monitor: any offered result must match the oldest expectation. The
    // result must also stay stable until accepted.
    always @(negedge clk) begin
        if (!reset) begin
            check("recv_rdy_vs_send_val", {63'd0, recv_rdy}, {63'd0, !send_val});
            if (send_val) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check("send_msg", {32'd0, send_msg}, {32'd0, exp_q[0].msg});
                    check("overflow", {63'd0, overflow}, {63'd0, exp_q[0].ovf});
                    if (send_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic beat(logic [31:0] msg, logic [7:0] cnt);
        int t = 0;
        recv_val = 1'b1;
        recv_msg = msg;
        count    = cnt;
        while (1) begin
            @(negedge clk);
            if (recv_rdy) break;
            t++;
            if (t > 300) begin
                check("recv_rdy_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        recv_msg = $urandom;
        count    = 8'($urandom);
    endtask

    task automatic run_sum(logic [7:0] cnt, logic [31:0] terms[$], int bub_at, int bub_len, bit rnd_bub);
        exp_q.push_back(model(terms));
        foreach (terms[i]) begin
            if (i > 0 && i == bub_at) repeat (bub_len) begin @(posedge clk); #1; end
            if (i > 0 && rnd_bub && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            // count on later beats is noise that must be ignored
            beat(terms[i], (i == 0) ? cnt : 8'($urandom));
        end
        check("send_val_latency", {63'd0, send_val}, 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tl[$];
        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        count    = '0;
        send_rdy = 1'b1;
        #12;
        check("reset_recv_rdy", {63'd0, recv_rdy}, 64'd1);
        check("reset_send_val", {63'd0, send_val}, 64'd0);
        check("reset_send_msg", {32'd0, send_msg}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // T1
        tl = '{32'h0001_8000, 32'h0002_4000};
        run_sum(8'd2, tl, 0, 0, 0);
        drain();
        // T2: bubble between beats 2 and 3
        tl = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
        run_sum(8'd3, tl, 2, 1, 0);
        drain();
        // T3 positive and negative clamps
        tl = '{32'h7FFF_0000, 32'h0002_0000};
        run_sum(8'd2, tl, 0, 0, 0);
        drain();
        tl = '{32'h8000_0000, 32'hFFFF_0000};
        run_sum(8'd2, tl, 0, 0, 0);
        drain();
        // Intermediate excursion that comes back in range is not an overflow
        tl = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000};
        run_sum(8'd3, tl, 0, 0, 0);
        drain();
        // T4: count=0 behaves as one term
        tl = '{32'h1234_5678};
        run_sum(8'd0, tl, 0, 0, 0);
        drain();

        // T5: result held for 5 cycles of send_rdy=0, transfer on the 6th
        rdy_forced = 1'b0;
        @(posedge clk); #1;
        tl = '{32'h0001_8000, 32'h0002_4000};
        run_sum(8'd2, tl, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_held_send_val", {63'd0, send_val}, 64'd1);
        check("t5_held_recv_rdy", {63'd0, recv_rdy}, 64'd0);
        rdy_forced = 1'b1;
        @(posedge clk); #1;
        check("t5_after_send_val", {63'd0, send_val}, 64'd0);
        check("t5_after_recv_rdy", {63'd0, recv_rdy}, 64'd1);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // T6: reset after 2 of 4 terms, then a fresh one-term sum
        beat(32'h0100_0000, 8'd4);
        beat(32'h0200_0000, 8'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_recv_rdy", {63'd0, recv_rdy}, 64'd1);
        check("t6_reset_send_val", {63'd0, send_val}, 64'd0);
        check("t6_reset_send_msg", {32'd0, send_msg}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tl = '{32'h0001_0000};
        run_sum(8'd1, tl, 0, 0, 0);
        drain();

        // Reset while a result is pending drops send_val immediately
        rdy_forced = 1'b0;
        @(posedge clk); #1;
        tl = '{32'h0000_0001, 32'h0000_0002};
        run_sum(8'd2, tl, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("done_reset_send_val", {63'd0, send_val}, 64'd0);
        check("done_reset_overflow", {63'd0, overflow}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_forced = 1'b1;

        // Maximum term count with full-scale negative terms
        tl.delete();
        repeat (255) tl.push_back(32'h8000_0000);
        run_sum(8'd255, tl, 0, 0, 0);
        drain();

        // Randomized sums with random bubbles and random downstream stalls
        rdy_random = 1'b1;
        for (int s = 0; s < 60; s++) begin
            int c;
            int nt;
            c  = $urandom_range(0, 12);
            nt = (c == 0) ? 1 : c;
            tl.delete();
            for (int k = 0; k < nt; k++) begin
                case ($urandom_range(0, 3))
                    0: tl.push_back(32'($urandom_range(0, 65535)) - 32'd32768);
                    1: tl.push_back($urandom);
                    2: tl.push_back(32'h7FF0_0000 | 32'($urandom_range(0, 20'hFFFFF)));
                    default: tl.push_back(32'h8000_0000 + 32'($urandom_range(0, 20'hFFFFF)));
                endcase
            end
            run_sum(8'(c), tl, 0, 0, 1);
        end
        drain();
        rdy_random = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
